sprite_sheet_server: RTL and testbench

SPRITE_SHEET_SERVER -- requirements
Module: sprite_sheet_server

---
 rtl/sprite_sheet_server.sv | 127 ++++++++++++
 tb/tb_sprite_sheet_server.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_sheet_server.sv
// Loadable DEPTH x DATA_W sprite sheet with a fully pipelined read port that has a fixed 2-cycle latency.
// Optional feature: define SPRITE_ERR_FLAG_EN to enable the sticky out-of-range flag range_err.

module sprite_sheet_server #(
    parameter int DEPTH  = 72000,
    parameter int DATA_W = 5,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_Out,
    output logic              data_valid,
    input  logic              load_start,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              sheet_ready,
    output logic              range_err
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_fire;
    logic              rd_in_range;
    logic [MEM_AW-1:0] rd_index;
    logic [MEM_AW-1:0] wr_index;

    logic              rd_valid_q;
    logic              rd_hit_q;
    logic [DATA_W-1:0] rd_data_q;

    // A reset cycle never writes, so an interrupted load leaves the sheet untouched from then on.
    assign wr_fire     = load_valid && load_ready && !Reset;
    assign rd_in_range = (read_address <= LAST_ADDR);
    assign rd_index    = read_address[MEM_AW-1:0];
    assign wr_index    = wr_ptr[MEM_AW-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            sheet_ready <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (load_start) begin
                        state       <= LOAD;
                        wr_ptr      <= '0;
                        load_ready  <= 1'b1;
                        sheet_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        if (wr_ptr == LAST_ADDR) begin
                            state       <= READY;
                            wr_ptr      <= '0;
                            load_ready  <= 1'b0;
                            load_done   <= 1'b1;
                            sheet_ready <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    wr_ptr      <= '0;
                    load_ready  <= 1'b0;
                    sheet_ready <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset so it maps onto block RAM; out-of-range reads alias harmlessly and are masked later.
    always_ff @(posedge Clk) begin
        if (wr_fire) begin
            mem[wr_index] <= load_data;
        end
        rd_data_q <= mem[rd_index];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            data_valid <= 1'b0;
            data_Out   <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_hit_q   <= rd_en && (state == READY) && rd_in_range;
            data_valid <= rd_valid_q;
            data_Out   <= (rd_valid_q && rd_hit_q) ? rd_data_q : '0;
        end
    end

`ifdef SPRITE_ERR_FLAG_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            range_err <= 1'b0;
        end else if (rd_en && !rd_in_range) begin
            range_err <= 1'b1;
        end
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_sheet_server.sv
// Self-checking bench for sprite_sheet_server: random loads and reads checked against an array-based sheet model.
// Expectations for range_err follow SPRITE_ERR_FLAG_EN exactly as the design build does.

module tb_sprite_sheet_server;

    localparam int DEPTH  = 72000;
    localparam int DATA_W = 5;
    localparam int ADDR_W = 19;

    logic              Clk;
    logic              Reset;
    logic [ADDR_W-1:0] read_address;
    logic              rd_en;
    logic [DATA_W-1:0] data_Out;
    logic              data_valid;
    logic              load_start;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              load_done;
    logic              sheet_ready;
    logic              range_err;

    int checks;
    int failures;

    int sheet [DEPTH];
    bit model_ready;
    bit model_err;

    sprite_sheet_server #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .read_address(read_address),
        .rd_en       (rd_en),
        .data_Out    (data_Out),
        .data_valid  (data_valid),
        .load_start  (load_start),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .sheet_ready (sheet_ready),
        .range_err   (range_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int exp_read(int addr);
        if (model_ready && addr < DEPTH) return sheet[addr];
        return 0;
    endfunction

    function automatic bit exp_err_flag();
`ifdef SPRITE_ERR_FLAG_EN
        return model_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        rd_en = 1'b1;
        read_address = ADDR_W'(7);
        step();
        step();
        model_ready = 1'b0;
        model_err = 1'b0;
        checks++;
        if ({data_valid, load_ready, load_done, sheet_ready, range_err} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {data_valid, load_ready, load_done, sheet_ready, range_err});
        end
        checks++;
        if (data_Out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %0d expected 0", data_Out);
        end
        Reset = 1'b0;
        rd_en = 1'b1;
        read_address = ADDR_W'(5);
        step();
        rd_en = 1'b0;
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_read_latency1: got data_valid=%b expected 0", data_valid);
        end
        step();
        checks++;
        if (data_valid !== 1'b1 || data_Out !== '0 || sheet_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_read: got valid=%b data=%0d sheet_ready=%b expected 1 0 0",
                     data_valid, data_Out, sheet_ready);
        end
        step();
        checks++;
        if (data_valid !== 1'b0 || data_Out !== '0) begin
            failures++;
            $display("[TB] FAIL idle_read_tail: got valid=%b data=%0d expected 0 0", data_valid, data_Out);
        end
    endtask

    task automatic test_full_load();
        int cnt;
        int cycles;
        int pulses;
        int ready_bad;
        bit v;
        logic final_done;
        logic final_ready;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        model_ready = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || sheet_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_enter: got load_ready=%b sheet_ready=%b expected 1 0", load_ready, sheet_ready);
        end
        cnt = 0;
        cycles = 0;
        pulses = 0;
        ready_bad = 0;
        final_done = 1'b0;
        final_ready = 1'b0;
        // The first stretch toggles load_valid at random and drives junk on stall cycles.
        while (cnt < DEPTH && cycles < DEPTH + 20000) begin
            v = (cnt < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
            load_valid = v;
            load_data = v ? DATA_W'(cnt % 20) : DATA_W'($urandom);
            if (load_ready !== 1'b1) ready_bad++;
            step();
            cycles++;
            if (v) begin
                sheet[cnt] = cnt % 20;
                cnt++;
            end
            if (load_done === 1'b1) pulses++;
            if (cnt == DEPTH) begin
                final_done = load_done;
                final_ready = sheet_ready;
            end
        end
        load_valid = 1'b0;
        model_ready = 1'b1;
        checks++;
        if (cnt != DEPTH) begin
            failures++;
            $display("[TB] FAIL load_timeout: got %0d writes expected %0d", cnt, DEPTH);
        end
        checks++;
        if (ready_bad != 0) begin
            failures++;
            $display("[TB] FAIL load_ready_during_load: got %0d low cycles expected 0", ready_bad);
        end
        checks++;
        if (final_done !== 1'b1 || final_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_done_at_end: got done=%b sheet_ready=%b expected 1 1", final_done, final_ready);
        end
        step();
        if (load_done === 1'b1) pulses++;
        step();
        if (load_done === 1'b1) pulses++;
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("[TB] FAIL load_done_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (load_ready !== 1'b0 || sheet_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_state: got load_ready=%b sheet_ready=%b expected 0 1", load_ready, sheet_ready);
        end
    endtask

    task automatic test_back_to_back();
        int addrs [5];
        addrs = '{241, 0, 1, 2, DEPTH - 1};
        for (int c = 0; c <= 5; c++) begin
            rd_en = (c < 5);
            read_address = (c < 5) ? ADDR_W'(addrs[c]) : '0;
            step();
            if (c >= 1) begin
                checks++;
                if (data_valid !== 1'b1 || data_Out !== DATA_W'(exp_read(addrs[c-1]))) begin
                    failures++;
                    $display("[TB] FAIL b2b_addr%0d: got valid=%b data=%0d expected 1 %0d",
                             addrs[c-1], data_valid, data_Out, exp_read(addrs[c-1]));
                end
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (data_valid !== 1'b0 || data_Out !== '0) begin
            failures++;
            $display("[TB] FAIL b2b_tail: got valid=%b data=%0d expected 0 0", data_valid, data_Out);
        end
    endtask

    task automatic test_out_of_range();
        checks++;
        if (range_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_before: got %b expected 0", range_err);
        end
        rd_en = 1'b1;
        read_address = ADDR_W'(DEPTH);
        model_err = 1'b1;
        step();
        rd_en = 1'b1;
        read_address = ADDR_W'(241);
        checks++;
        if (range_err !== exp_err_flag()) begin
            failures++;
            $display("[TB] FAIL err_set: got %b expected %b", range_err, exp_err_flag());
        end
        step();
        rd_en = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data_Out !== '0) begin
            failures++;
            $display("[TB] FAIL oor_data: got valid=%b data=%0d expected 1 0", data_valid, data_Out);
        end
        step();
        checks++;
        if (data_valid !== 1'b1 || data_Out !== DATA_W'(exp_read(241)) || range_err !== exp_err_flag()) begin
            failures++;
            $display("[TB] FAIL err_sticky: got valid=%b data=%0d err=%b expected 1 %0d %b",
                     data_valid, data_Out, range_err, exp_read(241), exp_err_flag());
        end
    endtask

    task automatic test_random_reads();
        int exp_q [$];
        int addr;
        int got;
        int want;
        for (int c = 0; c <= 301; c++) begin
            if (c < 300) begin
                rd_en = ($urandom_range(0, 3) != 0);
                addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2**ADDR_W - 1, DEPTH))
                                                   : int'($urandom_range(DEPTH - 1, 0));
            end else begin
                rd_en = 1'b0;
                addr = 0;
            end
            read_address = ADDR_W'(addr);
            if (rd_en && addr >= DEPTH) model_err = 1'b1;
            exp_q.push_back(rd_en ? (32'h100 | exp_read(addr)) : 0);
            step();
            if (c >= 1) begin
                want = exp_q.pop_front();
                got = {data_valid, 3'b000, data_Out};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL random_read_%0d: got valid=%b data=%0d expected valid=%0d data=%0d",
                             c - 1, data_valid, data_Out, want >> 8, want & 8'hff);
                end
            end
        end
        checks++;
        if (range_err !== exp_err_flag()) begin
            failures++;
            $display("[TB] FAIL random_err: got %b expected %b", range_err, exp_err_flag());
        end
    endtask

    task automatic test_reload_from_ready();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        model_ready = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || sheet_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reload_enter: got load_ready=%b sheet_ready=%b expected 1 0", load_ready, sheet_ready);
        end
        rd_en = 1'b1;
        read_address = ADDR_W'(241);
        step();
        rd_en = 1'b0;
        step();
        checks++;
        if (data_valid !== 1'b1 || data_Out !== DATA_W'(exp_read(241))) begin
            failures++;
            $display("[TB] FAIL read_in_load: got valid=%b data=%0d expected 1 %0d", data_valid, data_Out, exp_read(241));
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || sheet_ready !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_in_load: got ready=%b sheet=%b done=%b expected 1 0 0",
                     load_ready, sheet_ready, load_done);
        end
    endtask

    task automatic test_reset_in_flight();
        rd_en = 1'b1;
        read_address = ADDR_W'(3);
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        rd_en = 1'b0;
        model_ready = 1'b0;
        model_err = 1'b0;
        checks++;
        if ({data_valid, load_ready, sheet_ready, range_err} !== 4'b0 || data_Out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_read: got %b data=%0d expected 0000 0",
                     {data_valid, load_ready, sheet_ready, range_err}, data_Out);
        end
        step();
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flight_discard: got data_valid=%b expected 0", data_valid);
        end
    endtask

    task automatic test_reset_abort();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1;
            load_data = DATA_W'($urandom);
            step();
        end
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || load_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL partial_load: got ready=%b done=%b expected 1 0", load_ready, load_done);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        checks++;
        if (load_ready !== 1'b0 || sheet_ready !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle: got ready=%b sheet=%b done=%b expected 0 0 0",
                     load_ready, sheet_ready, load_done);
        end
        for (int c = 0; c <= 2; c++) begin
            rd_en = (c < 2);
            read_address = (c == 0) ? ADDR_W'(5) : ADDR_W'(50);
            step();
            if (c >= 1) begin
                checks++;
                if (data_valid !== 1'b1 || data_Out !== DATA_W'(exp_read(5))) begin
                    failures++;
                    $display("[TB] FAIL abort_read_%0d: got valid=%b data=%0d expected 1 0", c, data_valid, data_Out);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_ready = 1'b0;
        model_err = 1'b0;
        Reset = 1'b1;
        rd_en = 1'b0;
        read_address = '0;
        load_start = 1'b0;
        load_data = '0;
        load_valid = 1'b0;
        step();
        test_reset();
        test_full_load();
        test_back_to_back();
        test_out_of_range();
        test_random_reads();
        test_reload_from_ready();
        test_reset_in_flight();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
